// File: rtl/mt9v034_pattern_serializer.sv
// mt9v034_pattern_serializer
// Produces an MT9V034-style LVDS test stream: start bit, master pixel, optional
// slave pixel, stop bit, shifted out LSB first, one bit per enabled clock edge.
// Each word is either a sync/blank code or a clamped test-pattern pixel.
//
// Ports
//   clk          serial bit clock
//   rst          asynchronous active-high reset
//   enable       bit-rate clock enable; low freezes every register
//   pattern_sel  0 diagonal, 1 constant, 2 horizontal ramp, 3 LFSR
//   const_val    pixel value used by the constant pattern
//   ser_out      serial bit, ser_out_n its complement
//   word_start   high while ser_out carries bit 0 of a word
//   frame_valid  current word lies in a visible line
//   line_valid   current word is a visible pixel
//   frame_cnt    completed frames (wraps)
module mt9v034_pattern_serializer #(
    parameter int HPX    = 64,
    parameter int VPX    = 48,
    parameter int HBLANK = 24,
    parameter int VBLANK = 24,
    parameter int PIX_W  = 8,
    parameter int STEREO = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       pattern_sel,
    input  logic [PIX_W-1:0] const_val,
    output logic             ser_out,
    output logic             ser_out_n,
    output logic             word_start,
    output logic             frame_valid,
    output logic             line_valid,
    output logic [15:0]      frame_cnt
);

    localparam int HTOT = HPX + HBLANK;
    localparam int VTOT = VPX + VBLANK;
    localparam int WL   = (STEREO != 0) ? 18 : PIX_W + 2;
    localparam int XW   = $clog2(HTOT);
    localparam int YW   = $clog2(VTOT);
    localparam int BW   = $clog2(WL);
    localparam logic [PIX_W-1:0] MAX  = '1;
    localparam logic [15:0]      SEED = 16'hACE1;

    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WL-1:0]    sh_q, sh_d;
    logic             ser_q, ser_d;
    logic             ws_q, ws_d;
    logic             fv_q, fv_d;
    logic             lv_q, lv_d;
    logic [15:0]      fc_q, fc_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [1:0]       pat_q, pat_d;
    logic [PIX_W-1:0] const_q, const_d;

    int               xi, yi;
    logic             at_origin, visible;
    logic [1:0]       pat_cur;
    logic [PIX_W-1:0] const_cur, raw_m, master_w, slave_w, code;
    logic [15:0]      lfsr_cur;
    logic [WL-1:0]    load_word;

    function automatic logic [PIX_W-1:0] clamp(input logic [PIX_W-1:0] v);
        if (v < PIX_W'(4))
            return PIX_W'(4);
        else if (v == MAX)
            return MAX - PIX_W'(1);
        else
            return v;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Content of the word at the current position (x_q, y_q).
    always_comb begin
        xi        = int'(x_q);
        yi        = int'(y_q);
        at_origin = (xi == 0) && (yi == 0);
        visible   = (xi < HPX) && (yi < VPX);
        // Pattern selection and LFSR seed take effect at the first word of a frame.
        pat_cur   = at_origin ? pattern_sel : pat_q;
        const_cur = at_origin ? const_val : const_q;
        lfsr_cur  = at_origin ? SEED : lfsr_q;
        case (pat_cur)
            2'd0:    raw_m = PIX_W'(xi + yi + 4);
            2'd1:    raw_m = const_cur;
            2'd2:    raw_m = PIX_W'(xi);
            default: raw_m = lfsr_cur[PIX_W-1:0];
        endcase
        if (yi == VTOT - 1 && (xi == HTOT - 4 || xi == HTOT - 2))
            code = MAX;
        else if (yi == VTOT - 1 && xi == HTOT - 3)
            code = '0;
        else if (xi == HTOT - 1 && (yi == VTOT - 1 || yi < VPX - 1))
            code = PIX_W'(1);
        else if (xi == HPX && yi == VPX - 1)
            code = PIX_W'(3);
        else if (xi == HPX && yi < VPX - 1)
            code = PIX_W'(2);
        else
            code = PIX_W'(4);
        if (visible) begin
            master_w = clamp(raw_m);
            slave_w  = clamp(~raw_m);
        end else begin
            master_w = code;
            slave_w  = code;
        end
    end

    generate
        if (STEREO != 0) begin : g_stereo
            assign load_word = {1'b0, slave_w[7:0], master_w, 1'b1};
        end else begin : g_mono
            assign load_word = {1'b0, master_w, 1'b1};
        end
    endgenerate

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        ser_d   = ser_q;
        ws_d    = ws_q;
        fv_d    = fv_q;
        lv_d    = lv_q;
        fc_d    = fc_q;
        lfsr_d  = lfsr_q;
        pat_d   = pat_q;
        const_d = const_q;
        if (enable) begin
            if (bit_q == '0) begin
                // Load edge: emit bit 0 and step to the next word position.
                ser_d   = load_word[0];
                sh_d    = load_word >> 1;
                bit_d   = BW'(1);
                ws_d    = 1'b1;
                fv_d    = (yi < VPX);
                lv_d    = visible;
                pat_d   = pat_cur;
                const_d = const_cur;
                lfsr_d  = visible ? lfsr_step(lfsr_cur) : lfsr_cur;
                if (at_origin)
                    fc_d = fc_q + 16'd1;
                if (xi == HTOT - 1) begin
                    x_d = '0;
                    y_d = (yi == VTOT - 1) ? '0 : y_q + YW'(1);
                end else begin
                    x_d = x_q + XW'(1);
                end
            end else begin
                ser_d = sh_q[0];
                sh_d  = sh_q >> 1;
                ws_d  = 1'b0;
                bit_d = (bit_q == BW'(WL - 1)) ? '0 : bit_q + BW'(1);
            end
        end
    end

    // Reset parks the position on the last blanking line so the first
    // frame is preceded by its preamble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= YW'(VTOT - 1);
            bit_q   <= '0;
            sh_q    <= '0;
            ser_q   <= 1'b0;
            ws_q    <= 1'b0;
            fv_q    <= 1'b0;
            lv_q    <= 1'b0;
            fc_q    <= '0;
            lfsr_q  <= SEED;
            pat_q   <= '0;
            const_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            ser_q   <= ser_d;
            ws_q    <= ws_d;
            fv_q    <= fv_d;
            lv_q    <= lv_d;
            fc_q    <= fc_d;
            lfsr_q  <= lfsr_d;
            pat_q   <= pat_d;
            const_q <= const_d;
        end
    end

    assign ser_out     = ser_q;
    assign ser_out_n   = ~ser_q;
    assign word_start  = ws_q;
    assign frame_valid = fv_q;
    assign line_valid  = lv_q;
    assign frame_cnt   = fc_q;

endmodule

// File: tb/tb_mt9v034_pattern_serializer.sv
module tb_mt9v034_pattern_serializer;

    typedef struct {
        logic [17:0] w;
        logic        fv;
        logic        lv;
        logic [15:0] fc;
    } cap_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_a = 1'b1;
    logic        en_r = 1'b1;
    logic [1:0]  pat_a = 2'd0;
    logic [7:0]  const_a = 8'h00;

    logic        ser [3];
    logic        ser_n [3];
    logic        ws [3];
    logic        fv [3];
    logic        lv [3];
    logic [15:0] fc [3];

    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    // instance 0: enable=1, pattern changes; instance 1: random enable;
    // instance 2: mono 10-bit, horizontal ramp
    mt9v034_pattern_serializer #(.HPX(8), .VPX(4), .HBLANK(8), .VBLANK(2), .PIX_W(8), .STEREO(1)) dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .pattern_sel(pat_a), .const_val(const_a),
        .ser_out(ser[0]), .ser_out_n(ser_n[0]), .word_start(ws[0]),
        .frame_valid(fv[0]), .line_valid(lv[0]), .frame_cnt(fc[0]));

    mt9v034_pattern_serializer #(.HPX(8), .VPX(4), .HBLANK(8), .VBLANK(2), .PIX_W(8), .STEREO(1)) dut_r (
        .clk(clk), .rst(rst), .enable(en_r), .pattern_sel(2'd0), .const_val(8'h00),
        .ser_out(ser[1]), .ser_out_n(ser_n[1]), .word_start(ws[1]),
        .frame_valid(fv[1]), .line_valid(lv[1]), .frame_cnt(fc[1]));

    mt9v034_pattern_serializer #(.HPX(8), .VPX(4), .HBLANK(8), .VBLANK(2), .PIX_W(10), .STEREO(0)) dut_c (
        .clk(clk), .rst(rst), .enable(1'b1), .pattern_sel(2'd2), .const_val(10'd0),
        .ser_out(ser[2]), .ser_out_n(ser_n[2]), .word_start(ws[2]),
        .frame_valid(fv[2]), .line_valid(lv[2]), .frame_cnt(fc[2]));

    // ---------------- word capture ----------------
    logic        en_seen [3];
    int          nb [3];
    logic [17:0] acc [3];
    cap_t        meta [3];
    cap_t        qa[$];
    cap_t        qr[$];
    cap_t        qc[$];
    int          wl [3] = '{18, 18, 12};

    always @(posedge clk) begin
        en_seen[0] <= en_a & ~rst;
        en_seen[1] <= en_r & ~rst;
        en_seen[2] <= ~rst;
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            nb[i] = 0;
            acc[i] = '0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                nb[i] = 0;
            end else if (en_seen[i]) begin
                total++;
                assert (ws[i] === (nb[i] == 0)) else begin
                    bad++;
                    $error("FAIL word_start_pos inst=%0d bit=%0d observed=%b expected=%b", i, nb[i], ws[i], nb[i] == 0);
                end
                if (nb[i] == 0) begin
                    acc[i] = '0;
                    meta[i].fv = fv[i];
                    meta[i].lv = lv[i];
                    meta[i].fc = fc[i];
                end
                acc[i][nb[i]] = ser[i];
                nb[i]++;
                if (nb[i] == wl[i]) begin
                    meta[i].w = acc[i];
                    case (i)
                        0: qa.push_back(meta[i]);
                        1: qr.push_back(meta[i]);
                        default: qc.push_back(meta[i]);
                    endcase
                    nb[i] = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            en_r = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [17:0] mkw(input int m, input int s);
        return 18'(1 + (m << 1) + (s << 9));
    endfunction

    function automatic int qsize(input int which);
        case (which)
            0: return qa.size();
            1: return qr.size();
            default: return qc.size();
        endcase
    endfunction

    function automatic cap_t qget(input int which, input int k);
        case (which)
            0: return qa[k];
            1: return qr[k];
            default: return qc[k];
        endcase
    endfunction

    task automatic chk(input string tag, input int which, input int k, input logic [17:0] ew,
                       input logic efv, input logic elv, input logic [15:0] efc);
        cap_t e;
        bit   got;
        got = 0;
        for (int c = 0; c < 20000; c++) begin
            if (qsize(which) > k) begin
                got = 1;
                break;
            end
            @(posedge clk);
        end
        if (got) begin
            e = qget(which, k);
        end else begin
            e.w = 'x; e.fv = 'x; e.lv = 'x; e.fc = 'x;
        end
        total++;
        assert ({e.w, e.fv, e.lv, e.fc} === {ew, efv, elv, efc}) else begin
            bad++;
            $error("FAIL %s word=%0d observed w=%0h fv=%b lv=%b fc=%0d expected w=%0h fv=%b lv=%b fc=%0d (timeout=%0d)",
                   tag, k, e.w, e.fv, e.lv, e.fc, ew, efv, elv, efc, !got);
        end
    endtask

    task automatic chk1(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit hit;
        int n0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk1("rst_ser_out",     16'(ser[0]),   16'd0);
        chk1("rst_ser_out_n",   16'(ser_n[0]), 16'd1);
        chk1("rst_word_start",  16'(ws[0]),    16'd0);
        chk1("rst_frame_valid", 16'(fv[0]),    16'd0);
        chk1("rst_line_valid",  16'(lv[0]),    16'd0);
        chk1("rst_frame_cnt",   fc[0],         16'd0);
        rst = 1'b0;

        // preamble line y=5 then first frame, diagonal pattern
        chk("first_word",    0, 0,  mkw(4, 4),     0, 0, 0);
        chk("pre_max_a",     0, 12, mkw(255, 255), 0, 0, 0);
        chk("pre_zero",      0, 13, mkw(0, 0),     0, 0, 0);
        chk("pre_max_b",     0, 14, mkw(255, 255), 0, 0, 0);
        chk("pre_linestart", 0, 15, mkw(1, 1),     0, 0, 0);
        chk("origin_f1",     0, 16, mkw(4, 251),   1, 1, 1);
        chk("line_end",      0, 24, mkw(2, 2),     1, 0, 1);
        chk("line_start_y0", 0, 31, mkw(1, 1),     1, 0, 1);
        chk("pix_3_2",       0, 51, mkw(9, 246),   1, 1, 1);
        // switch to constant 0 mid-frame: must not affect this frame
        pat_a = 2'd1;
        const_a = 8'h00;
        chk("pix_7_3_hold",  0, 71, mkw(14, 241),  1, 1, 1);
        chk("frame_end",     0, 72, mkw(3, 3),     1, 0, 1);
        chk("no_ls_y3",      0, 79, mkw(4, 4),     1, 0, 1);
        chk("blank_y4",      0, 95, mkw(4, 4),     0, 0, 1);
        chk("const_origin",  0, 112, mkw(4, 254),  1, 1, 2);
        chk("const_5_1",     0, 133, mkw(4, 254),  1, 1, 2);
        pat_a = 2'd3;
        chk("lfsr_seed",     0, 208, mkw(225, 30), 1, 1, 3);
        chk("lfsr_step1",    0, 209, mkw(195, 60), 1, 1, 3);

        // random-enable instance must reconstruct the same stream
        chk("ren_first",     1, 0,  mkw(4, 4),     0, 0, 0);
        chk("ren_pre_max_a", 1, 12, mkw(255, 255), 0, 0, 0);
        chk("ren_pre_zero",  1, 13, mkw(0, 0),     0, 0, 0);
        chk("ren_pre_max_b", 1, 14, mkw(255, 255), 0, 0, 0);
        chk("ren_pre_ls",    1, 15, mkw(1, 1),     0, 0, 0);
        chk("ren_origin",    1, 16, mkw(4, 251),   1, 1, 1);
        chk("ren_line_end",  1, 24, mkw(2, 2),     1, 0, 1);
        chk("ren_pix_3_2",   1, 51, mkw(9, 246),   1, 1, 1);
        chk("ren_frame_end", 1, 72, mkw(3, 3),     1, 0, 1);

        // mono 10-bit, 12-bit words: 1 | m<<1
        chk("mono_max_a",    2, 12, 18'd2047, 0, 0, 0);
        chk("mono_zero",     2, 13, 18'd1,    0, 0, 0);
        chk("mono_max_b",    2, 14, 18'd2047, 0, 0, 0);
        chk("mono_ls",       2, 15, 18'd3,    0, 0, 0);
        chk("mono_x0_clamp", 2, 16, 18'd9,    1, 1, 1);
        chk("mono_x5",       2, 21, 18'd11,   1, 1, 1);

        // reset in the middle of a word aborts it
        hit = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            #1;
            if (nb[0] == 7) begin
                hit = 1;
                break;
            end
        end
        chk1("abort_reach_midword", 16'(hit), 16'd1);
        #1 rst = 1'b1;
        #1;
        chk1("abort_ser_out",     16'(ser[0]),   16'd0);
        chk1("abort_ser_out_n",   16'(ser_n[0]), 16'd1);
        chk1("abort_word_start",  16'(ws[0]),    16'd0);
        chk1("abort_frame_valid", 16'(fv[0]),    16'd0);
        chk1("abort_line_valid",  16'(lv[0]),    16'd0);
        chk1("abort_frame_cnt",   fc[0],         16'd0);
        @(negedge clk);
        n0 = qa.size();
        @(negedge clk);
        rst = 1'b0;
        chk("abort_restart", 0, n0, mkw(4, 4), 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
